tpm_lifecycle_ctrl: RTL
=======================

# tpm_lifecycle_ctrl

Parametrised TPM lifecycle controller. It tracks the operational state (power-off, init, startup, operational, self-test, failure, shutdown) and decodes TPM2_Startup and TPM2_Shutdown. It sequences self-tests over a configurable number of test engines through a req/done handshake, keeps width-configurable saturating reset/restart/clear counters, and returns a TPM response code per accepted command. It sits between the command decoder and the per-command execution units and forwards non-lifecycle commands only when the TPM state allows them.

## Interface
Parameters:
- CNT_W, 32, width of reset_count/restart_count/clear_count
- NUM_TESTS, 40, number of self-test engines (≥2); TIDX_W = $clog2(NUM_TESTS)

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- orderly_init  in  1  NV orderly flag, sampled in POWER_OFF
- cmd_valid  in  1  command present
- cmd_ready  out  1  high while op_state ∈ {INIT, OPERATIONAL, FAILURE}
- tpm_cc  in  32  command code
- cmd_param  in  16  bit0 = startupType/shutdownType/fullTest
- rsp_valid  out  1  one-cycle response strobe
- rsp_code  out  32  TPM_RC value, valid with rsp_valid
- cmd_fwd  out  1  one-cycle pulse: forward command to execution units
- test_req  out  1  self-test request, held until test_done
- test_idx  out  TIDX_W  test being requested
- test_done  in  1  test complete (ignored unless test_req=1)
- test_pass  in  1  result, sampled with test_done
- op_state  out  3  0 POWER_OFF, 1 INIT, 2 STARTUP, 3 OPERATIONAL, 4 SELF_TEST, 5 FAILURE, 6 SHUTDOWN
- startup_type  out  2  0 none, 1 RESET, 2 RESTART, 3 RESUME
- ph_enable, ph_enable_nv, sh_enable, eh_enable  out  1 each  hierarchy enables
- s_initialized  out  1  a successful Startup has completed
- shutdown_save  out  1  last Shutdown type was SU_STATE
- untested_mask  out  NUM_TESTS  bit i = test i not yet passed since TPM Reset
- reset_count, restart_count, clear_count  out  CNT_W  saturating counters

## Operation
- Command codes: STARTUP 0x144, SHUTDOWN 0x145, SELFTEST 0x143, INCREMENTALSELFTEST 0x142, GETTESTRESULT 0x17C, GETCAPABILITY 0x17A.
- Response codes: SUCCESS 0x000, INITIALIZE 0x100, FAILURE 0x101, VALUE 0x084.
- A command is accepted when cmd_valid & cmd_ready.
- POWER_OFF: one cycle. The internal orderly register loads orderly_init, then the state moves to INIT.
- INIT: Startup goes to STARTUP. Any other command returns INITIALIZE and the state stays INIT.
- STARTUP: decode {orderly, param0}:
  - 1,0 → RESTART
  - 1,1 → RESUME
  - 0,0 → RESET
  - 0,1 → return VALUE, go back to INIT with nothing changed.
- On a valid startup: ph_enable=1, s_initialized=1, orderly=0, startup_type updated, state → OPERATIONAL, return SUCCESS.
  - RESET: reset_count+1, restart_count=0, clear_count=0, ph_enable_nv/sh/eh=1, untested_mask all ones.
  - RESTART: restart_count+1, clear_count+1, ph_enable_nv/sh/eh=1.
  - RESUME: restart_count+1, ph_enable_nv/sh/eh preserved.
- Counters saturate at 2^CNT_W−1 and never wrap.
- OPERATIONAL:
  - Startup returns INITIALIZE.
  - Shutdown → SHUTDOWN.
  - SelfTest → SELF_TEST, with the selection set to all tests if param0=1, otherwise untested_mask.
  - IncrementalSelfTest → SELF_TEST with selection = untested_mask.
  - Any other code: cmd_fwd pulse, return SUCCESS.
- SHUTDOWN: one cycle. orderly=1, shutdown_save=param0 captured at accept, return SUCCESS, → OPERATIONAL.
- SELF_TEST: a scan index runs 0..NUM_TESTS−1.
  - An unselected index costs one cycle.
  - A selected index raises test_req with test_idx=index and waits for test_done.
  - Pass: clear untested_mask[idx] and advance.
  - Fail: drop test_req, → FAILURE, return FAILURE.
  - After the last index: → OPERATIONAL, return SUCCESS. An empty selection finishes in NUM_TESTS cycles.
- FAILURE: terminal until reset. GetTestResult/GetCapability give cmd_fwd + SUCCESS. All other commands return FAILURE.
- Reset values: op_state=0, all counters 0, orderly=0, shutdown_save=0, s_initialized=0, all enables 0, startup_type=0, untested_mask all ones, test_req=0, test_idx=0, rsp_valid=0, rsp_code=0, cmd_fwd=0.
- Reset asserted mid-test drops test_req immediately (asynchronously).

## Timing
- All outputs are registered except cmd_ready, which is decoded from op_state.
- Immediate commands (INIT rejects, forwards, OPERATIONAL/FAILURE rejects): rsp_valid and cmd_fwd high in cycle N+1 after the accept cycle N.
- Startup and Shutdown: rsp_valid in N+2; the state, counters and enables update on the same edge that raises rsp_valid.
- cmd_ready is low during STARTUP/SHUTDOWN/SELF_TEST, so back-to-back immediate commands are accepted every cycle.
- test_req rises one cycle after the scan reaches a selected index.
- When test_done is sampled high, test_req falls on the next edge and the following index is examined on the next cycle. Minimum spacing between selected tests is 2 cycles.
- The final rsp_valid comes one cycle after the last test_done or the last skipped index.

## Test plan
- Reset, orderly_init=0, Startup(param0=0) → rsp 0x000 at N+2, startup_type=1, reset_count=1, ph_enable/ph_enable_nv/sh_enable/eh_enable all 1, op_state=3.
- Startup, then Shutdown(param0=1), then Startup(param0=1) → RESUME, restart_count=1, clear_count unchanged, sh_enable/eh_enable preserved. Repeat with a second Startup → rsp 0x100.
- Reset with orderly_init=0, Startup(param0=1) → rsp 0x084, op_state=1. Any non-Startup command in INIT → 0x100.
- NUM_TESTS=4, SelfTest(param0=1), all pass → test_idx 0,1,2,3 in order, untested_mask=0, rsp 0x000. Then IncrementalSelfTest → no test_req, rsp after 4 cycles.
- SelfTest with test 2 failing → op_state=5, rsp 0x101. Then GetCapability → cmd_fwd + 0x000, and Startup → 0x101.
- CNT_W=2: 4 RESTART cycles → restart_count and clear_count saturate at 3. Reset asserted while test_req=1 → test_req=0 immediately, op_state=0.

Source files
------------

// File: rtl/tpm_lifecycle_ctrl.sv
// TPM lifecycle controller: operational-state tracking, Startup/Shutdown decode,
// self-test sequencing over NUM_TESTS engines and saturating lifecycle counters.
module tpm_lifecycle_ctrl #(
  parameter int  CNT_W     = 32,
  parameter int  NUM_TESTS = 40,
  localparam int TIDX_W    = $clog2(NUM_TESTS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 orderly_init,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          tpm_cc,
  input  logic [15:0]          cmd_param,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_code,
  output logic                 cmd_fwd,
  output logic                 test_req,
  output logic [TIDX_W-1:0]    test_idx,
  input  logic                 test_done,
  input  logic                 test_pass,
  output logic [2:0]           op_state,
  output logic [1:0]           startup_type,
  output logic                 ph_enable,
  output logic                 ph_enable_nv,
  output logic                 sh_enable,
  output logic                 eh_enable,
  output logic                 s_initialized,
  output logic                 shutdown_save,
  output logic [NUM_TESTS-1:0] untested_mask,
  output logic [CNT_W-1:0]     reset_count,
  output logic [CNT_W-1:0]     restart_count,
  output logic [CNT_W-1:0]     clear_count
);

  typedef enum logic [2:0] {
    ST_POWER_OFF   = 3'd0,
    ST_INIT        = 3'd1,
    ST_STARTUP     = 3'd2,
    ST_OPERATIONAL = 3'd3,
    ST_SELF_TEST   = 3'd4,
    ST_FAILURE     = 3'd5,
    ST_SHUTDOWN    = 3'd6
  } state_e;

  localparam logic [31:0] CC_INC_SELFTEST = 32'h0000_0142;
  localparam logic [31:0] CC_SELFTEST     = 32'h0000_0143;
  localparam logic [31:0] CC_STARTUP      = 32'h0000_0144;
  localparam logic [31:0] CC_SHUTDOWN     = 32'h0000_0145;
  localparam logic [31:0] CC_GETCAP       = 32'h0000_017A;
  localparam logic [31:0] CC_GETTESTRES   = 32'h0000_017C;

  localparam logic [31:0] RC_SUCCESS      = 32'h0000_0000;
  localparam logic [31:0] RC_VALUE        = 32'h0000_0084;
  localparam logic [31:0] RC_INITIALIZE   = 32'h0000_0100;
  localparam logic [31:0] RC_FAILURE      = 32'h0000_0101;

  localparam logic [1:0] SU_RESET   = 2'd1;
  localparam logic [1:0] SU_RESTART = 2'd2;
  localparam logic [1:0] SU_RESUME  = 2'd3;

  localparam logic [TIDX_W-1:0] LAST_IDX = TIDX_W'(NUM_TESTS - 1);

  state_e               r_state, w_state;
  logic                 r_orderly, w_orderly;
  logic                 r_param0, w_param0;
  logic                 r_shutdown_save, w_shutdown_save;
  logic                 r_s_init, w_s_init;
  logic                 r_ph, w_ph;
  logic                 r_ph_nv, w_ph_nv;
  logic                 r_sh, w_sh;
  logic                 r_eh, w_eh;
  logic [1:0]           r_startup_type, w_startup_type;
  logic [NUM_TESTS-1:0] r_untested, w_untested;
  logic [NUM_TESTS-1:0] r_sel, w_sel;
  logic [TIDX_W-1:0]    r_scan_idx, w_scan_idx;
  logic                 r_test_req, w_test_req;
  logic [TIDX_W-1:0]    r_test_idx, w_test_idx;
  logic                 r_rsp_valid, w_rsp_valid;
  logic [31:0]          r_rsp_code, w_rsp_code;
  logic                 r_cmd_fwd, w_cmd_fwd;
  logic [CNT_W-1:0]     r_reset_cnt, w_reset_cnt;
  logic [CNT_W-1:0]     r_restart_cnt, w_restart_cnt;
  logic [CNT_W-1:0]     r_clear_cnt, w_clear_cnt;

  logic w_accept;
  logic w_last;
  logic w_unused_param;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (&val) begin
      res = val;
    end else begin
      res = val + CNT_W'(1);
    end
    return res;
  endfunction

  assign cmd_ready      = (r_state == ST_INIT) || (r_state == ST_OPERATIONAL) ||
                          (r_state == ST_FAILURE);
  assign w_accept       = cmd_valid & cmd_ready;
  assign w_last         = (r_scan_idx == LAST_IDX);
  assign w_unused_param = ^cmd_param[15:1];

  // Next-state and next-output decode for every lifecycle register.
  always_comb begin
    w_state         = r_state;
    w_orderly       = r_orderly;
    w_param0        = r_param0;
    w_shutdown_save = r_shutdown_save;
    w_s_init        = r_s_init;
    w_ph            = r_ph;
    w_ph_nv         = r_ph_nv;
    w_sh            = r_sh;
    w_eh            = r_eh;
    w_startup_type  = r_startup_type;
    w_untested      = r_untested;
    w_sel           = r_sel;
    w_scan_idx      = r_scan_idx;
    w_test_req      = r_test_req;
    w_test_idx      = r_test_idx;
    w_rsp_valid     = 1'b0;
    w_rsp_code      = r_rsp_code;
    w_cmd_fwd       = 1'b0;
    w_reset_cnt     = r_reset_cnt;
    w_restart_cnt   = r_restart_cnt;
    w_clear_cnt     = r_clear_cnt;

    case (r_state)
      ST_POWER_OFF: begin
        w_orderly = orderly_init;
        w_state   = ST_INIT;
      end

      ST_INIT: begin
        if (w_accept) begin
          if (tpm_cc == CC_STARTUP) begin
            w_param0 = cmd_param[0];
            w_state  = ST_STARTUP;
          end else begin
            w_rsp_valid = 1'b1;
            w_rsp_code  = RC_INITIALIZE;
          end
        end else begin
          w_state = ST_INIT;
        end
      end

      // A non-orderly shutdown cannot be resumed: reject without side effects.
      ST_STARTUP: begin
        w_rsp_valid = 1'b1;
        if (!r_orderly && r_param0) begin
          w_rsp_code = RC_VALUE;
          w_state    = ST_INIT;
        end else begin
          w_rsp_code = RC_SUCCESS;
          w_state    = ST_OPERATIONAL;
          w_ph       = 1'b1;
          w_s_init   = 1'b1;
          w_orderly  = 1'b0;
          case ({r_orderly, r_param0})
            2'b00: begin
              w_startup_type = SU_RESET;
              w_reset_cnt    = sat_inc(r_reset_cnt);
              w_restart_cnt  = {CNT_W{1'b0}};
              w_clear_cnt    = {CNT_W{1'b0}};
              w_ph_nv        = 1'b1;
              w_sh           = 1'b1;
              w_eh           = 1'b1;
              w_untested     = {NUM_TESTS{1'b1}};
            end
            2'b10: begin
              w_startup_type = SU_RESTART;
              w_restart_cnt  = sat_inc(r_restart_cnt);
              w_clear_cnt    = sat_inc(r_clear_cnt);
              w_ph_nv        = 1'b1;
              w_sh           = 1'b1;
              w_eh           = 1'b1;
            end
            2'b11: begin
              w_startup_type = SU_RESUME;
              w_restart_cnt  = sat_inc(r_restart_cnt);
            end
            default: begin
              w_startup_type = r_startup_type;
            end
          endcase
        end
      end

      ST_OPERATIONAL: begin
        if (w_accept) begin
          case (tpm_cc)
            CC_STARTUP: begin
              w_rsp_valid = 1'b1;
              w_rsp_code  = RC_INITIALIZE;
            end
            CC_SHUTDOWN: begin
              w_param0 = cmd_param[0];
              w_state  = ST_SHUTDOWN;
            end
            CC_SELFTEST: begin
              w_sel      = cmd_param[0] ? {NUM_TESTS{1'b1}} : r_untested;
              w_scan_idx = {TIDX_W{1'b0}};
              w_state    = ST_SELF_TEST;
            end
            CC_INC_SELFTEST: begin
              w_sel      = r_untested;
              w_scan_idx = {TIDX_W{1'b0}};
              w_state    = ST_SELF_TEST;
            end
            default: begin
              w_cmd_fwd   = 1'b1;
              w_rsp_valid = 1'b1;
              w_rsp_code  = RC_SUCCESS;
            end
          endcase
        end else begin
          w_state = ST_OPERATIONAL;
        end
      end

      ST_SHUTDOWN: begin
        w_orderly       = 1'b1;
        w_shutdown_save = r_param0;
        w_rsp_valid     = 1'b1;
        w_rsp_code      = RC_SUCCESS;
        w_state         = ST_OPERATIONAL;
      end

      // test_req doubles as the wait-for-done phase of the scan.
      ST_SELF_TEST: begin
        if (r_test_req) begin
          if (test_done) begin
            w_test_req = 1'b0;
            if (test_pass) begin
              w_untested[r_test_idx] = 1'b0;
              if (w_last) begin
                w_rsp_valid = 1'b1;
                w_rsp_code  = RC_SUCCESS;
                w_state     = ST_OPERATIONAL;
              end else begin
                w_scan_idx = r_scan_idx + TIDX_W'(1);
              end
            end else begin
              w_rsp_valid = 1'b1;
              w_rsp_code  = RC_FAILURE;
              w_state     = ST_FAILURE;
            end
          end else begin
            w_test_req = 1'b1;
          end
        end else if (r_sel[r_scan_idx]) begin
          w_test_req = 1'b1;
          w_test_idx = r_scan_idx;
        end else if (w_last) begin
          w_rsp_valid = 1'b1;
          w_rsp_code  = RC_SUCCESS;
          w_state     = ST_OPERATIONAL;
        end else begin
          w_scan_idx = r_scan_idx + TIDX_W'(1);
        end
      end

      ST_FAILURE: begin
        if (w_accept) begin
          w_rsp_valid = 1'b1;
          if ((tpm_cc == CC_GETTESTRES) || (tpm_cc == CC_GETCAP)) begin
            w_cmd_fwd  = 1'b1;
            w_rsp_code = RC_SUCCESS;
          end else begin
            w_rsp_code = RC_FAILURE;
          end
        end else begin
          w_state = ST_FAILURE;
        end
      end

      default: begin
        w_test_req = 1'b0;
        w_state    = ST_FAILURE;
      end
    endcase
  end

  // State and output registers; reset also kills an in-flight test request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_POWER_OFF;
      r_orderly       <= 1'b0;
      r_param0        <= 1'b0;
      r_shutdown_save <= 1'b0;
      r_s_init        <= 1'b0;
      r_ph            <= 1'b0;
      r_ph_nv         <= 1'b0;
      r_sh            <= 1'b0;
      r_eh            <= 1'b0;
      r_startup_type  <= 2'd0;
      r_untested      <= {NUM_TESTS{1'b1}};
      r_sel           <= {NUM_TESTS{1'b0}};
      r_scan_idx      <= {TIDX_W{1'b0}};
      r_test_req      <= 1'b0;
      r_test_idx      <= {TIDX_W{1'b0}};
      r_rsp_valid     <= 1'b0;
      r_rsp_code      <= 32'h0000_0000;
      r_cmd_fwd       <= 1'b0;
      r_reset_cnt     <= {CNT_W{1'b0}};
      r_restart_cnt   <= {CNT_W{1'b0}};
      r_clear_cnt     <= {CNT_W{1'b0}};
    end else begin
      r_state         <= w_state;
      r_orderly       <= w_orderly;
      r_param0        <= w_param0;
      r_shutdown_save <= w_shutdown_save;
      r_s_init        <= w_s_init;
      r_ph            <= w_ph;
      r_ph_nv         <= w_ph_nv;
      r_sh            <= w_sh;
      r_eh            <= w_eh;
      r_startup_type  <= w_startup_type;
      r_untested      <= w_untested;
      r_sel           <= w_sel;
      r_scan_idx      <= w_scan_idx;
      r_test_req      <= w_test_req;
      r_test_idx      <= w_test_idx;
      r_rsp_valid     <= w_rsp_valid;
      r_rsp_code      <= w_rsp_code;
      r_cmd_fwd       <= w_cmd_fwd;
      r_reset_cnt     <= w_reset_cnt;
      r_restart_cnt   <= w_restart_cnt;
      r_clear_cnt     <= w_clear_cnt;
    end
  end

  assign op_state      = r_state;
  assign startup_type  = r_startup_type;
  assign ph_enable     = r_ph;
  assign ph_enable_nv  = r_ph_nv;
  assign sh_enable     = r_sh;
  assign eh_enable     = r_eh;
  assign s_initialized = r_s_init;
  assign shutdown_save = r_shutdown_save;
  assign untested_mask = r_untested;
  assign test_req      = r_test_req;
  assign test_idx      = r_test_idx;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_code      = r_rsp_code;
  assign cmd_fwd       = r_cmd_fwd;
  assign reset_count   = r_reset_cnt;
  assign restart_count = r_restart_cnt;
  assign clear_count   = r_clear_cnt;

endmodule
